// File: rtl/memory_allocate.sv
// Data-memory and write-back-select stage of the single-cycle RV32 core.
// Word-organised RAM, combinational read, one-edge write, synchronous clear.
module memory_allocate #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_out,
  input  logic [31:0] data_rs2,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        memtoreg,
  output logic [31:0] data_value
);

  logic [DEPTH-1:0][31:0] mem_q;
  logic [ADDR_W-1:0]      idx;
  logic                   in_range;
  logic [31:0]            rd_data;

  // Byte address bits [1:0] are dropped; anything above the word index must be zero.
  assign idx      = alu_out[ADDR_W+1:2];
  assign in_range = ((alu_out >> (ADDR_W + 2)) == 32'h0);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else if (mem_write && in_range) begin
      mem_q[idx] <= data_rs2;
    end
  end

  always_comb begin
    rd_data = 32'h0;
    if (mem_read && in_range) rd_data = mem_q[idx];
  end

  assign data_value = memtoreg ? rd_data : alu_out;

endmodule

// File: tb/tb_memory_allocate.sv
// Self-checking bench for memory_allocate: directed plan steps followed by
// random traffic, all compared against a word-array reference model.
module tb_memory_allocate;

  localparam int DEPTH = 256;
  localparam logic [32:0] LIMIT = 33'(DEPTH * 4);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_out, data_rs2;
  logic        mem_read, mem_write, memtoreg;
  logic [31:0] data_value;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem_m [DEPTH];

  memory_allocate #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .alu_out(alu_out), .data_rs2(data_rs2),
    .mem_read(mem_read), .mem_write(mem_write), .memtoreg(memtoreg),
    .data_value(data_value)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_val(logic [31:0] a, logic rd, logic m2r);
    if (!m2r) return a;
    if (!rd) return 32'h0;
    if ({1'b0, a} < LIMIT) return mem_m[a >> 2];
    return 32'h0;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    end else if (mem_write && ({1'b0, alu_out} < LIMIT)) begin
      mem_m[alu_out >> 2] = data_rs2;
    end
  endtask

  task automatic drive(logic [31:0] a, logic [31:0] d, logic rd, logic wr,
                       logic m2r, logic rst);
    alu_out = a; data_rs2 = d; mem_read = rd; mem_write = wr;
    memtoreg = m2r; reset = rst;
    #1;
  endtask

  // One clock cycle: check before the edge (old contents), apply edge, check after.
  task automatic cycle(string tag, logic [31:0] a, logic [31:0] d, logic rd,
                       logic wr, logic m2r, logic rst);
    drive(a, d, rd, wr, m2r, rst);
    check({tag, "_pre"}, data_value, exp_val(a, rd, m2r));
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_post"}, data_value, exp_val(a, rd, m2r));
  endtask

  initial begin
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    model_edge();
    #1;
    check("rst_alu", data_value, 32'h0);
    drive(32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("rst_mem", data_value, 32'h0);
    drive(32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_pass", data_value, 32'h0000_0040);

    cycle("st0", 32'h0, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ld0", data_value, 32'h0000_1234);
    drive(32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("m2r0", data_value, 32'h0);
    drive(32'h5678_9ABC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pass", data_value, 32'h5678_9ABC);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("nord", data_value, 32'h0);

    cycle("st10", 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("st14", 32'h14, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(32'h13, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ld13", data_value, 32'hDEAD_BEEF);
    drive(32'h14, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ld14", data_value, 32'hCAFE_F00D);

    // Read-during-write at the same address: old value, then new.
    drive(32'h10, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b1, 1'b0);
    check("rdw_old", data_value, 32'hDEAD_BEEF);
    @(posedge clk);
    model_edge();
    #1;
    check("rdw_new", data_value, 32'h0BAD_F00D);

    cycle("st400", 32'h400, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ld400", data_value, 32'h0);
    drive(32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ld0_keep", data_value, 32'h0000_1234);
    drive(32'h3FC, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ld3fc", data_value, 32'h0);

    cycle("st8", 32'h8, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(32'h8, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ld8", data_value, 32'hA5A5_A5A5);
    cycle("rst_wr", 32'h8, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(32'h8, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ld8_clr", data_value, 32'h0);
    drive(32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ld10_clr", data_value, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1100));
      cycle("rnd", a, 32'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 49) == 0));
    end

    // Read back every word against the model.
    for (int i = 0; i < DEPTH; i++) begin
      drive(32'(i * 4), 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("sweep", data_value, mem_m[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
